// File: rtl/fpu_frame_buff.sv
// fpu_frame_buff: assembles UART byte frames into FPU operands,
// launches the FPU and streams the result back to the UART.
module fpu_frame_buff #(
   parameter int         OP_BYTES    = 4,
   parameter bit         BIG_ENDIAN  = 1'b1,
   parameter int         TIMEOUT_CYC = 50000,
   parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            data_in,
   input  logic                  en,
   output logic [8*OP_BYTES-1:0] fpu_a,
   output logic [8*OP_BYTES-1:0] fpu_b,
   output logic [1:0]            fpu_op,
   output logic                  fpu_start,
   input  logic                  fpu_done,
   input  logic [8*OP_BYTES-1:0] fpu_result,
   output logic [7:0]            toTx,
   output logic                  wr_en,
   input  logic                  Tx_busy,
   output logic [7:0]            bulbs
);

   localparam int CW = $clog2(2*OP_BYTES+1);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC+1) : 1;
   localparam logic [CW-1:0] NB       = CW'(OP_BYTES);
   localparam logic [CW-1:0] NB_M1    = CW'(OP_BYTES-1);
   localparam logic [CW-1:0] OPC_IDX  = CW'(2*OP_BYTES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC-1);

   typedef enum logic [1:0] {
      RX   = 2'b00,
      EXEC = 2'b01,
      TX   = 2'b10,
      TXW  = 2'b11
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]         cnt;
   logic [CW-1:0]         tx_idx;
   logic [TW-1:0]         timer;
   logic [8*OP_BYTES-1:0] res;
   logic                  guard;
   logic                  err_pay;
   logic                  ill_flag;
   logic                  drop_flag;
   logic                  tmo_flag;

   logic                  rx_take;
   logic                  is_opc;
   logic                  tmo_hit;
   logic                  op_legal;
   logic [1:0]            op_code;
   logic                  tx_fire;
   logic                  tx_last;
   logic                  txw_go;
   logic [CW-1:0]         rx_sel;
   logic [CW-1:0]         rx_pos;
   logic [CW-1:0]         tx_pos;
   logic [7:0]            tx_byte;

   // Frame bookkeeping, opcode decode and payload byte selection.
   always_comb begin
      rx_take  = (state == RX) && en;
      is_opc   = (cnt == OPC_IDX);
      tmo_hit  = (state == RX) && !en && (cnt != '0) && (timer == TMO_LAST);
      op_legal = 1'b1;
      op_code  = 2'b00;
      unique case (data_in)
         8'hF0:   op_code = 2'b00;
         8'h0F:   op_code = 2'b01;
         8'h33:   op_code = 2'b10;
         8'hCC:   op_code = 2'b11;
         default: op_legal = 1'b0;
      endcase
      rx_sel  = (cnt < NB) ? cnt : cnt - NB;
      rx_pos  = BIG_ENDIAN ? NB_M1 - rx_sel : rx_sel;
      tx_pos  = BIG_ENDIAN ? NB_M1 - tx_idx : tx_idx;
      tx_byte = err_pay ? ERR_BYTE : res[{tx_pos, 3'b000} +: 8];
      tx_fire = (state == TX) && !Tx_busy;
      tx_last = err_pay || (tx_idx == NB_M1);
      txw_go  = (state == TXW) && !guard && !Tx_busy;
   end

   // Next-state selection for the frame / execute / transmit sequence.
   always_comb begin
      state_nxt = state;
      unique case (state)
         RX:   if (rx_take && is_opc) state_nxt = op_legal ? EXEC : TX;
         EXEC: if (fpu_done) state_nxt = TX;
         TX:   if (tx_fire) state_nxt = TXW;
         TXW:  if (txw_go) state_nxt = tx_last ? RX : TX;
         default: state_nxt = RX;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RX;
      else      state <= state_nxt;
   end

   // Operand capture, timeout timer, result latch and transmit datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         tx_idx    <= '0;
         timer     <= '0;
         res       <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         fpu_op    <= 2'b00;
         fpu_start <= 1'b0;
         wr_en     <= 1'b0;
         toTx      <= 8'h00;
         guard     <= 1'b0;
         err_pay   <= 1'b0;
         ill_flag  <= 1'b0;
         drop_flag <= 1'b0;
         tmo_flag  <= 1'b0;
      end else begin
         fpu_start <= 1'b0;
         wr_en     <= 1'b0;
         guard     <= tx_fire;
         if (en && state != RX) drop_flag <= 1'b1;
         if (rx_take) begin
            timer <= '0;
            if (is_opc) begin
               cnt    <= '0;
               tx_idx <= '0;
               if (op_legal) begin
                  fpu_op    <= op_code;
                  fpu_start <= 1'b1;
                  err_pay   <= 1'b0;
               end else begin
                  ill_flag <= 1'b1;
                  err_pay  <= 1'b1;
               end
            end else begin
               cnt <= cnt + CW'(1);
               if (cnt < NB) fpu_a[{rx_pos, 3'b000} +: 8] <= data_in;
               else          fpu_b[{rx_pos, 3'b000} +: 8] <= data_in;
            end
         end else if (tmo_hit) begin
            cnt      <= '0;
            timer    <= '0;
            tmo_flag <= 1'b1;
         end else if (state == RX && cnt != '0) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
         if (state == EXEC && fpu_done) begin
            res    <= fpu_result;
            tx_idx <= '0;
         end
         if (tx_fire) begin
            toTx  <= tx_byte;
            wr_en <= 1'b1;
         end
         if (txw_go && !tx_last) tx_idx <= tx_idx + CW'(1);
      end
   end

   assign bulbs = {state, 3'b000, ill_flag, drop_flag, tmo_flag};

endmodule

// File: tb/tb_fpu_frame_buff.sv
// tb_fpu_frame_buff: directed and random frames against a byte-level
// reference model, with FPU and UART transmitter stubs.
module tb_fpu_frame_buff;

   localparam int NB  = 4;
   localparam int TMO = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        en = 1'b0;
   logic [31:0] fpu_a, fpu_b;
   logic [1:0]  fpu_op;
   logic        fpu_start;
   logic        fpu_done = 1'b0;
   logic [31:0] fpu_result = '0;
   logic [7:0]  toTx;
   logic        wr_en;
   logic        Tx_busy;
   logic [7:0]  bulbs;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   logic        force_busy = 1'b0;
   int          busy_cnt = 0;
   int          lat = 0;
   logic [31:0] stub_val = '0;
   logic [7:0]  tx_q[$];
   logic [1:0]  op_q[$];
   int          start_cyc = 0;
   bit          exp_ill = 0;

   fpu_frame_buff #(
      .OP_BYTES(NB), .BIG_ENDIAN(1'b1),
      .TIMEOUT_CYC(TMO), .ERR_BYTE(8'hEE)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .en(en),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_start(fpu_start), .fpu_done(fpu_done),
      .fpu_result(fpu_result), .toTx(toTx), .wr_en(wr_en),
      .Tx_busy(Tx_busy), .bulbs(bulbs)
   );

   always #5 clk = ~clk;

   assign Tx_busy = force_busy | (busy_cnt != 0);

   // transmitter stub: busy for 10 cycles after each request
   always @(negedge clk) begin
      if (wr_en) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
   end

   // FPU stub: 5-cycle latency, one-cycle done pulse
   always @(negedge clk) begin
      fpu_done = 1'b0;
      if (lat > 0) begin
         lat--;
         if (lat == 0) begin
            fpu_done   = 1'b1;
            fpu_result = stub_val;
         end
      end
      if (fpu_start) lat = 5;
   end

   // output monitor
   always @(negedge clk) begin
      if (wr_en) tx_q.push_back(toTx);
      if (fpu_start) begin
         start_cyc++;
         op_q.push_back(fpu_op);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_op(input logic [7:0] opc,
                                    output bit legal,
                                    output logic [1:0] op);
      legal = 1;
      op    = 2'b00;
      case (opc)
         8'hF0:   op = 2'b00;
         8'h0F:   op = 2'b01;
         8'h33:   op = 2'b10;
         8'hCC:   op = 2'b11;
         default: legal = 0;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data_in = b;
      en      = 1'b1;
      @(negedge clk);
      en      = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                             input logic [7:0] opc);
      for (int i = 0; i < NB; i++) send_byte(a[31-8*i -: 8]);
      for (int i = 0; i < NB; i++) send_byte(b[31-8*i -: 8]);
      send_byte(opc);
   endtask

   task automatic finish_frame(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [7:0] opc,
                               input logic [31:0] res, input int txb,
                               input int stb);
      bit         legal;
      logic [1:0] op;
      logic [7:0] e;
      logic [7:0] g;
      logic [1:0] og;
      int         n;
      int         k;
      model_op(opc, legal, op);
      n = legal ? NB : 1;
      if (!legal) exp_ill = 1;
      k = 0;
      while (k < 800 && !(tx_q.size() >= txb + n && bulbs[7:6] == 2'b00)) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, 64'(k < 800), 64'd1);
      repeat (3) @(negedge clk);
      chk({tag, "_a"}, 64'(fpu_a), 64'(a));
      chk({tag, "_b"}, 64'(fpu_b), 64'(b));
      chk({tag, "_starts"}, 64'(start_cyc - stb), legal ? 64'd1 : 64'd0);
      if (legal) begin
         og = (op_q.size() > 0) ? op_q[op_q.size()-1] : 2'bxx;
         chk({tag, "_op"}, 64'(og), 64'(op));
      end
      chk({tag, "_nbytes"}, 64'(tx_q.size() - txb), 64'(n));
      e = 8'h00;
      for (int i = 0; i < n; i++) begin
         e = legal ? res[31-8*i -: 8] : 8'hEE;
         g = (txb + i < tx_q.size()) ? tx_q[txb+i] : 8'hxx;
         chk($sformatf("%s_byte%0d", tag, i), 64'(g), 64'(e));
      end
      chk({tag, "_hold"}, 64'(toTx), 64'(e));
      chk({tag, "_ill"}, 64'(bulbs[2]), 64'(exp_ill));
      chk({tag, "_rx"}, 64'(bulbs[7:6]), 64'd0);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [7:0] opc,
                            input logic [31:0] res);
      int txb;
      int stb;
      txb      = tx_q.size();
      stb      = start_cyc;
      stub_val = res;
      send_frame(a, b, opc);
      finish_frame(tag, a, b, opc, res, txb, stb);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_fa"}, 64'(fpu_a), 64'd0);
      chk({tag, "_fb"}, 64'(fpu_b), 64'd0);
      chk({tag, "_op"}, 64'(fpu_op), 64'd0);
      chk({tag, "_st"}, 64'(fpu_start), 64'd0);
      chk({tag, "_wr"}, 64'(wr_en), 64'd0);
      chk({tag, "_tx"}, 64'(toTx), 64'd0);
      chk({tag, "_bulbs"}, 64'(bulbs), 64'd0);
   endtask

   initial begin
      logic [7:0]  opt[4];
      logic [31:0] ra, rb, rr;
      logic [7:0]  ro;
      int          txb;
      int          stb;
      opt = '{8'hF0, 8'h0F, 8'h33, 8'hCC};

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run_frame("add", 32'h3F800000, 32'h40000000, 8'hF0, 32'h40400000);
      run_frame("div", 32'h40A00000, 32'h40000000, 8'hCC, 32'h40200000);
      run_frame("illegal", 32'h3F800000, 32'h40000000, 8'h55, 32'h0);

      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      repeat (TMO - 10) @(negedge clk);
      chk("tmo_early", 64'(bulbs[0]), 64'd0);
      repeat (20) @(negedge clk);
      chk("tmo_set", 64'(bulbs[0]), 64'd1);
      run_frame("mul", 32'hBF800000, 32'h40000000, 8'h33, 32'hC0000000);
      chk("tmo_sticky", 64'(bulbs[0]), 64'd1);

      ra = $urandom;
      rb = $urandom;
      rr = $urandom;
      txb = tx_q.size();
      stb = start_cyc;
      stub_val = rr;
      force_busy = 1'b1;
      chk("drop_clear", 64'(bulbs[1]), 64'd0);
      send_frame(ra, rb, 8'h0F);
      send_byte(8'hA5);
      send_byte(8'h5A);
      repeat (100) @(negedge clk);
      chk("busy_nowr", 64'(tx_q.size() - txb), 64'd0);
      chk("busy_state", 64'(bulbs[7:6]), 64'd2);
      chk("drop_set", 64'(bulbs[1]), 64'd1);
      force_busy = 1'b0;
      finish_frame("busy", ra, rb, 8'h0F, rr, txb, stb);

      for (int t = 0; t < 5; t++) begin
         ra = $urandom;
         rb = $urandom;
         rr = $urandom;
         ro = (t == 4) ? 8'($urandom) : opt[$urandom_range(0, 3)];
         run_frame($sformatf("rnd%0d", t), ra, rb, ro, rr);
      end

      txb = tx_q.size();
      stb = start_cyc;
      for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("midrst");
      repeat (20) @(negedge clk);
      chk("midrst_nowr", 64'(tx_q.size() - txb), 64'd0);
      chk("midrst_nost", 64'(start_cyc - stb), 64'd0);
      exp_ill = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_frame("after_rst", 32'h3F800000, 32'h40000000, 8'hF0, 32'h40400000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fpu_frame_buff.md
FPU_FRAME_BUFF -- requirements
Module: fpu_frame_buff

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- OP_BYTES, 4, bytes per operand and per result (legal 1..8).
- BIG_ENDIAN, 1, 1 = first byte received and sent is the MS byte; 0 = LS byte first.
- TIMEOUT_CYC, 50000, idle cycles allowed between bytes of a partial frame.
- ERR_BYTE, 8'hEE, byte transmitted in place of a result for an illegal opcode.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-low reset.
- data_in  in  8  received byte from the UART receiver.
- en  in  1  byte strobe; each cycle with en=1 delivers one byte.
- fpu_a  out  8*OP_BYTES  operand A.
- fpu_b  out  8*OP_BYTES  operand B.
- fpu_op  out  2  operation code: 00 add, 01 sub, 10 mul, 11 div.
- fpu_start  out  1  one-cycle start pulse to the FPU.
- fpu_done  in  1  one-cycle completion pulse from the FPU.
- fpu_result  in  8*OP_BYTES  FPU result, valid while fpu_done=1.
- toTx  out  8  byte to the UART transmitter.
- wr_en  out  1  one-cycle transmit request.
- Tx_busy  in  1  transmitter busy.
- bulbs  out  8  status LEDs (REQ-012).

Function
REQ-003 Frame format SHALL be OP_BYTES bytes of A, then OP_BYTES bytes of B, then 1 opcode byte (2*OP_BYTES+1 bytes total).
REQ-004 The FSM SHALL have states RX, EXEC, TX, TXW.
- RX: a byte counter 0..2*OP_BYTES advances on each en=1.
- After the opcode byte the FSM SHALL leave RX.
REQ-005 Bytes SHALL be placed into fpu_a/fpu_b per BIG_ENDIAN; fpu_a/fpu_b SHALL hold stable from the edge that captures the opcode until the next frame's first byte.
REQ-006 Opcode decode: F0 = add, 0F = sub, 33 = mul, CC = div; any other value is illegal.
REQ-007 For a legal opcode captured at edge N:
- fpu_start SHALL be 1 for exactly the cycle following edge N, with fpu_op valid in that cycle.
- The FSM SHALL then enter EXEC.
REQ-008 In EXEC, fpu_done=1 SHALL latch fpu_result into an internal result register and enter TX.
- EXEC has no timeout.
REQ-009 For an illegal opcode, fpu_start SHALL stay 0 and the FSM SHALL go directly to TX with a 1-byte payload of ERR_BYTE.
REQ-010 Transmit handshake:
- TX: when Tx_busy=0, drive toTx with the next payload byte, pulse wr_en for one cycle, enter TXW.
- TXW: ignore Tx_busy for the first cycle (guard), then wait for Tx_busy=0.
- After the guard: return to TX if bytes remain, else return to RX with the counter cleared.
- Result bytes SHALL be sent in BIG_ENDIAN order, OP_BYTES bytes per frame.
REQ-011 Partial-frame timeout: in RX with counter>0 and TIMEOUT_CYC consecutive cycles without en, the counter SHALL clear, the partial frame SHALL be discarded, and the timeout flag SHALL set.
REQ-012 bulbs mapping:
- [7:6] state encoding (RX=00, EXEC=01, TX=10, TXW=11).
- [5:3] = 0.
- [2] illegal-opcode flag, sticky.
- [1] dropped-byte flag, sticky: en=1 seen outside RX.
- [0] timeout flag, sticky.
- Sticky flags SHALL clear only on reset.
REQ-013 Boundary rules:
- en=1 outside RX SHALL be ignored and set the dropped-byte flag.
- fpu_done outside EXEC SHALL be ignored.
- If en=1 and the timeout expiry occur in the same cycle, the byte SHALL be accepted and the timer restarted.
- toTx SHALL hold its value between wr_en pulses.

Reset
REQ-014 rst=0 SHALL asynchronously force: state RX, counter 0, timer 0, fpu_a=fpu_b=0, fpu_op=0, fpu_start=0, wr_en=0, toTx=0, result register 0, bulbs=0.
- A reset mid-frame, mid-EXEC or mid-TX SHALL abandon the operation with no further wr_en or fpu_start.
REQ-015 Deassertion of rst SHALL take effect on the first clk rising edge after release; no byte SHALL be accepted in the release cycle.

Verification (OP_BYTES=4, BIG_ENDIAN=1, FPU stub with 5-cycle latency, Tx stub busy 10 cycles per byte)
REQ-016 Frame 3F800000, 40000000, F0; stub returns 40400000 -> one fpu_start with fpu_op=00, then toTx 40,40,00,00 each with one wr_en pulse.
REQ-017 Frame 40A00000, 40000000, CC; stub returns 40200000 -> fpu_op=11, then toTx 40,20,00,00.
REQ-018 Frame 3F800000, 40000000, 55 -> no fpu_start, a single wr_en with toTx=EE, bulbs[2]=1, FSM back in RX.
REQ-019 Three bytes, then no en for TIMEOUT_CYC cycles -> bulbs[0]=1; a following full frame (BF800000, 40000000, 33; stub C0000000) -> toTx C0,00,00,00.
REQ-020 Tx_busy held high 100 cycles while in TX -> no wr_en until Tx_busy falls; en pulses sent during EXEC -> bulbs[1]=1 and the result is unchanged.
REQ-021 rst=0 asserted after the 6th byte of a frame -> all outputs 0 immediately; a complete new frame afterwards produces the correct result.
